// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared memory-side types and widths for the store buffer    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int SB_DEPTH = 4;
  localparam int WADDR_W  = 30;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  data;
  } sb_entry_t;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_buffer_fifo : circular entry storage with per-entry search      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  sb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic [WADDR_W-1:0]            search_waddr,
  output sb_entry_t                     head_entry,
  output logic [$clog2(DEPTH)-1:0]      head_ptr,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              match,
  output logic [DEPTH-1:0][DATA_W-1:0]  entry_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: validity is derived from head/count only.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= push_entry;
  end

  assign head_entry = r_mem[r_head];
  assign head_ptr   = r_head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] w_offset;
    logic             w_valid;
    assign w_offset      = PTR_W'(i) - r_head;
    assign w_valid       = ({1'b0, w_offset} < r_count);
    assign match[i]      = w_valid && (r_mem[i].waddr == search_waddr);
    assign entry_data[i] = r_mem[i].data;
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_buffer : write-behind store buffer with load forwarding         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t                    w_push_entry;
  sb_entry_t                    w_head_entry;
  logic [PTR_W-1:0]             w_head_ptr;
  logic [DEPTH-1:0]             w_match;
  logic [DEPTH-1:0][DATA_W-1:0] w_entry_data;
  logic                         w_push;
  logic                         w_drain;
  logic                         w_load;
  logic                         w_fwd_hit;
  logic [DATA_W-1:0]            w_fwd_data;
  logic [PTR_W-1:0]             w_idx;

  assign w_push_entry.waddr = word_addr(cpu_addr);
  assign w_push_entry.data  = cpu_din;

  // A simultaneous read+write is a store; only a pure read is a load.
  assign w_load  = cpu_mem_read && !cpu_mem_write;
  assign stall   = !reset && cpu_mem_write && full;
  assign w_push  = !reset && cpu_mem_write && !full;
  assign w_drain = !reset && !empty &&
                   ((!cpu_mem_read && !cpu_mem_write) || (cpu_mem_write && full));

  store_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (w_push),
    .push_entry  (w_push_entry),
    .pop         (w_drain),
    .search_waddr(word_addr(cpu_addr)),
    .head_entry  (w_head_entry),
    .head_ptr    (w_head_ptr),
    .full        (full),
    .empty       (empty),
    .match       (w_match),
    .entry_data  (w_entry_data)
  );

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_head_ptr + PTR_W'(k);
      if (w_match[w_idx]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entry_data[w_idx];
      end
    end
  end

  always_comb begin
    mem_write = w_drain;
    mem_addr  = cpu_addr;
    mem_din   = '0;
    if (w_drain) begin
      mem_addr = {w_head_entry.waddr, 2'b00};
      mem_din  = w_head_entry.data;
    end
  end

  always_comb begin
    mem_read = 1'b0;
    cpu_dout = '0;
    if (!reset && w_load) begin
      if (w_fwd_hit) begin
        cpu_dout = w_fwd_data;
      end else begin
        mem_read = 1'b1;
        cpu_dout = mem_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_buffer : directed bench with a behavioural data memory       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_mem_read, cpu_mem_write;
  logic        stall, mem_read, mem_write, full, empty;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic [31:0] tbmem [0:1023];
  logic        mem_clr;
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;
  int          wr_cnt;
  int          wr_base;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_dout     (cpu_dout),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_dout     (mem_dout),
    .full         (full),
    .empty        (empty)
  );

  assign mem_dout = tbmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) tbmem[i] <= 32'h0;
      wr_cnt <= 0;
    end else begin
      if (pre_en) tbmem[pre_idx] <= pre_data;
      if (mem_write) begin
        tbmem[mem_addr[11:2]] <= mem_din;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_mem_read  = rd;
    cpu_mem_write = wr;
    cpu_addr      = a;
    cpu_din       = d;
    #2;
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    set_in(1'b1, 1'b1, 32'h40, 32'h99);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read",  mem_read,  0);
    check("rst_stall",     stall,     0);
    check("rst_cpu_dout",  cpu_dout,  0);
    step;
    mem_clr = 1'b0; pre_en = 1'b1; pre_idx = 10'(32'h300 >> 2); pre_data = 32'hDEADBEEF;
    set_in(1'b1, 1'b0, 32'h40, 32'h0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_rd_cpu_dout", cpu_dout, 0);
    step;
    pre_en = 1'b0; reset = 1'b0;

    // single store then drain on idle
    set_in(1'b0, 1'b1, 32'h100, 32'hAAAA0001);
    check("st1_stall", stall, 0);
    check("st1_no_drain", mem_write, 0);
    step;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    check("st1_mem_write", mem_write, 1);
    check("st1_mem_addr",  mem_addr,  32'h100);
    check("st1_mem_din",   mem_din,   32'hAAAA0001);
    step;
    check("st1_empty", empty, 1);
    check("st1_memory", tbmem[32'h100 >> 2], 32'hAAAA0001);

    // youngest-match forwarding
    set_in(1'b0, 1'b1, 32'h200, 32'h11); step;
    set_in(1'b0, 1'b1, 32'h200, 32'h22);
    check("fwd_second_no_drain", mem_write, 0);
    step;
    set_in(1'b1, 1'b0, 32'h202, 32'h0);
    check("fwd_cpu_dout", cpu_dout, 32'h22);
    check("fwd_mem_read", mem_read, 0);
    check("fwd_no_drain", mem_write, 0);
    step;
    set_in(1'b0, 1'b0, 32'h0, 32'h0); step;
    check("fwd_first_drain", tbmem[32'h200 >> 2], 32'h11);
    step;
    check("fwd_order_final", tbmem[32'h200 >> 2], 32'h22);
    check("fwd_empty", empty, 1);

    // load miss with a buffered store present
    set_in(1'b0, 1'b1, 32'h50, 32'h1); step;
    set_in(1'b1, 1'b0, 32'h300, 32'h0);
    check("miss_mem_read", mem_read, 1);
    check("miss_mem_addr", mem_addr, 32'h300);
    check("miss_cpu_dout", cpu_dout, 32'hDEADBEEF);
    check("miss_no_drain", mem_write, 0);
    step;
    // read+write together is a store only
    set_in(1'b1, 1'b1, 32'h300, 32'h5);
    check("rw_cpu_dout", cpu_dout, 0);
    check("rw_mem_read", mem_read, 0);
    step;
    set_in(1'b0, 1'b0, 32'h0, 32'h0); step; step;
    check("rw_drained_50", tbmem[32'h50 >> 2], 32'h1);
    check("rw_drained_300", tbmem[32'h300 >> 2], 32'h5);

    // fill, stall with concurrent drain, then accept
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 32'(4 * i), 32'hA0 + 32'(i));
      step;
    end
    set_in(1'b0, 1'b1, 32'h10, 32'hA4);
    check("full_flag",   full,      1);
    check("full_stall",  stall,     1);
    check("full_drain",  mem_write, 1);
    check("full_d_addr", mem_addr,  32'h0);
    check("full_d_din",  mem_din,   32'hA0);
    step;
    set_in(1'b0, 1'b1, 32'h10, 32'hA4);
    check("retry_stall", stall,     0);
    check("retry_full",  full,      0);
    check("retry_nodrain", mem_write, 0);
    step;
    set_in(1'b1, 1'b0, 32'h10, 32'h0);
    check("refill_full", full, 1);
    check("refill_fwd",  cpu_dout, 32'hA4);
    step;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step;
    check("fill_empty", empty, 1);
    check("fill_mem0",  tbmem[0], 32'hA0);
    check("fill_mem10", tbmem[4], 32'hA4);

    // reset discards buffered entries
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'hB0 + 32'(i));
      step;
    end
    wr_base = wr_cnt;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    check("disc_rst_mem_write", mem_write, 0);
    step;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    check("disc_empty", empty, 1);
    check("disc_no_write", mem_write, 0);
    step; step; step;
    check("disc_wr_count", 32'(wr_cnt), 32'(wr_base));
    check("disc_mem400", tbmem[32'h400 >> 2], 32'h0);

    // pointer wrap over store/idle pairs
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h1000 + 32'(i));
      step;
      set_in(1'b0, 1'b0, 32'h0, 32'h0);
      check("wrap_drain_addr", mem_addr, 32'h500 + 32'(4 * i));
      step;
    end
    for (int i = 0; i < 10; i++)
      check("wrap_memory", tbmem[(32'h500 >> 2) + i], 32'h1000 + 32'(i));
    check("wrap_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
